// File: rtl/fifo_burst_drain.sv
// Burst drain for the synchronous FIFO: pops up to BURST_LEN words per trigger into a
// 2-entry skid buffer feeding a valid/ready stream. Optional idle flush: FIFO_BURST_DRAIN_TIMEOUT_EN.
module fifo_burst_drain #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned BURST_LEN      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fifo_empty,
  input  logic                  i_fifo_thr_trig,
  input  logic [ADDR_WIDTH:0]   i_fifo_count,
  output logic                  o_fifo_rd,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_last,
  output logic                  o_busy
);

  localparam logic [ADDR_WIDTH:0] BurstLenC = (ADDR_WIDTH + 1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0] OneC      = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {StIdle, StBurst, StFinish} state_e;

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]   r_len, r_rem, r_beat;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf0, r_buf1;

  logic                  w_start, w_pop, w_room;
  logic [2:0]            w_level;
  logic [ADDR_WIDTH:0]   w_len_new;

`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IdleW-1:0] r_idle_cnt;
  logic             w_timeout;

  assign w_timeout = (r_idle_cnt == IdleW'(TIMEOUT_CYCLES));
  assign w_start   = !i_fifo_empty && (i_fifo_thr_trig || w_timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (r_state != StIdle || w_start) begin
      r_idle_cnt <= '0;
    end else if (!i_fifo_empty && !i_fifo_thr_trig) begin
      r_idle_cnt <= r_idle_cnt + IdleW'(1);
    end else begin
      r_idle_cnt <= '0;
    end
  end
`else
  assign w_start = !i_fifo_empty && i_fifo_thr_trig;
`endif

  assign w_len_new = (i_fifo_count < BurstLenC) ? i_fifo_count : BurstLenC;
  assign w_pop     = o_m_valid & i_m_ready;
  // Slots committed to the buffer (held + arriving) must stay below 2 after this cycle's pop.
  assign w_level   = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_room    = w_level < (3'd2 + {2'b00, w_pop});

  assign o_m_valid = (r_occ != 2'd0);
  assign o_m_data  = r_buf0;
  assign o_m_last  = o_m_valid && (r_beat == (r_len - OneC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:   if (w_start) w_state_nxt = StBurst;
      StBurst:  if (o_fifo_rd && (r_rem == OneC)) w_state_nxt = StFinish;
      StFinish: if (w_pop && o_m_last) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_busy    = (r_state != StIdle);
    o_fifo_rd = (r_state == StBurst) && (r_rem != '0) && !i_fifo_empty && w_room;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= '0;
      r_rem  <= '0;
      r_beat <= '0;
    end else if (r_state == StIdle && w_start) begin
      r_len  <= w_len_new;
      r_rem  <= w_len_new;
      r_beat <= '0;
    end else begin
      if (o_fifo_rd) r_rem <= r_rem - OneC;
      if (w_pop && o_m_last) begin
        r_beat <= '0;
      end else if (w_pop) begin
        r_beat <= r_beat + OneC;
      end
    end
  end

  // Read data arrives one cycle after the pop; r_inflight marks that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_inflight <= o_fifo_rd;
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0 <= i_fifo_rd_data;
          end else begin
            r_buf1 <= i_fifo_rd_data;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= i_fifo_rd_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= i_fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
